// File: rtl/cdc_pkg.sv
// Shared types and default sizes for the toggle req/ack CDC handshake.
package cdc_pkg;

    // Source-side handshake FSM states.
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } hs_state_e;

    // Default depth of the ack synchronizer chain (must be >= 2).
    localparam int DEF_SYNC_STAGES = 2;

    // Default width of a transferred control word.
    localparam int DEF_DATA_W = 32;

endpackage : cdc_pkg

// File: rtl/ack_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level (the ack toggle).
// The output is the last stage; input-to-output latency is STAGES cycles.
module ack_sync_chain
    import cdc_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the asynchronous level one stage deeper each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
    end

    // Chain registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule : ack_sync_chain

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a two-phase (toggle) req/ack CDC handshake.
// A word accepted on s_valid/s_ready is held on data_o while req_o toggles;
// the transfer completes when the synchronized ack toggle matches req_o.
// Optional ack timeout with sticky err: define HS_TIMEOUT_EN.
//
// Handshake: a word is transferred on every rising clk edge where
// s_valid && s_ready; s_ready never depends on s_valid, and s_data is
// only sampled on that edge.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              err
);

    hs_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_s;
    logic              ack_match;
    logic              accept;

    ack_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (ack_i),
        .q_o   (ack_s)
    );

    // The destination has caught up when its synchronized ack equals our req.
    assign ack_match = (ack_s == req_q);
    assign s_ready   = (state_q == IDLE) && ack_match && !reset;
    assign accept    = s_valid && s_ready;

    // Next-state, captured word, req toggle and completion count.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = s_data;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_o    = req_q;
    assign data_o   = data_q;
    assign busy     = (state_q == WAIT_ACK);
    assign xfer_cnt = cnt_q;

`ifdef HS_TIMEOUT_EN
    localparam int               TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            err_q, err_d;

    // Count WAIT_ACK cycles (saturating) and latch err once the limit is hit.
    always_comb begin
        tcnt_d = tcnt_q;
        err_d  = err_q;
        if (state_q == IDLE) begin
            if (accept) begin
                tcnt_d = '0;
            end
        end else if (tcnt_q != TO_MAX) begin
            tcnt_d = tcnt_q + TO_W'(1);
        end
        if ((state_q == WAIT_ACK) && !ack_match && (tcnt_d == TO_MAX)) begin
            err_d = 1'b1;
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign err            = 1'b0;
`endif

endmodule : cdc_handshake_tx

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: randomized words, a destination
// ack model, a scoreboard queue of expected words and a req-toggle monitor.
module tb_cdc_handshake_tx;

  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int TIMEOUT_CYC = 8;
`ifdef HS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              req_o;
  logic [DATA_W-1:0] data_o;
  logic              ack_i;
  logic              busy;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              err;

  // destination ack: model-driven or manual
  logic dest_en;
  logic dest_ack;
  logic man_ack;
  int   dest_lat;
  assign ack_i = dest_en ? dest_ack : man_ack;

  // reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_req;
  int                exp_cnt;
  int                n_tests;
  int                n_fail;

  cdc_handshake_tx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .req_o    (req_o),
    .data_o   (data_o),
    .ack_i    (ack_i),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .err      (err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- destination model ----------------
  initial begin
    dest_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (dest_en && !reset && (req_o != dest_ack)) begin
        repeat (dest_lat) @(posedge clk);
        #1;
        if (dest_en) dest_ack = req_o;
      end
    end
  end

  // ---------------- monitor ----------------
  logic              mon_prev_req;
  logic [DATA_W-1:0] mon_held;
  logic [DATA_W-1:0] mon_w;
  always @(negedge clk) begin
    if (reset) begin
      mon_prev_req = 1'b0;
      mon_held     = '0;
    end else if (req_o !== mon_prev_req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req_toggle", 32'(req_o), 32'(mon_prev_req));
      end else begin
        mon_w = exp_q.pop_front();
        check("data_at_req", data_o, mon_w);
      end
      mon_prev_req = req_o;
      mon_held     = data_o;
    end else begin
      check("data_hold", data_o, mon_held);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    exp_q.delete();
    exp_req = 1'b0;
    exp_cnt = 0;
  endtask

  // reset held across full cycles so the monitor always sees it
  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    #1;
    while (!s_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(w);
    exp_req = ~exp_req;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = DATA_W'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("req_after_accept", 32'(req_o), 32'(exp_req));
    check("ready_low_in_wait", 32'(s_ready), 32'd0);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy) begin
      @(negedge clk);
      cycles++;
      if (cycles > 200) begin
        check("idle_timeout", 32'(busy), 32'd0);
        return;
      end
    end
    exp_cnt++;
    check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt % (1 << CNT_W)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [DATA_W-1:0] w;
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    dest_en  = 1'b0;
    man_ack  = 1'b0;
    dest_lat = 3;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready_in_reset", 32'(s_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(s_ready), 32'd1);

    // 1: single word, manual ack, busy falls SYNC_STAGES+1 cycles after ack
    send_word(32'hA5A5_0001);
    check("t1_data", data_o, 32'hA5A5_0001);
    man_ack = 1'b1;
    wait_idle(cyc);
    check("t1_ack_latency", 32'(cyc), 32'(SYNC_STAGES + 1));
    check("t1_ready_back", 32'(s_ready), 32'd1);
    check("t1_err", 32'(err), 32'd0);

    // 2: four random words, destination acks 3 cycles after req
    dest_ack = man_ack;
    dest_en  = 1'b1;
    dest_lat = 3;
    for (int i = 0; i < 4; i++) begin
      w = DATA_W'($urandom);
      send_word(w);
      wait_idle(cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("t2_req_level", 32'(req_o), 32'(exp_req));
    check("t2_err", 32'(err), 32'd0);

    // 3: spurious ack toggle in IDLE stalls s_ready, no accept, no err
    @(negedge clk);
    man_ack = dest_ack;
    dest_en = 1'b0;
    man_ack = ~exp_req;
    repeat (3) @(negedge clk);
    s_valid = 1'b1;
    s_data  = DATA_W'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_ready_stalled", 32'(s_ready), 32'd0);
      check("t3_no_accept", 32'(busy), 32'd0);
      check("t3_err", 32'(err), 32'd0);
    end
    s_valid = 1'b0;
    man_ack = exp_req;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    check("t3_ready_restored", 32'(s_ready), 32'd1);
    check("t3_req_kept", 32'(req_o), 32'(exp_req));

    // 4: reset during WAIT_ACK
    send_word(DATA_W'($urandom));
    @(negedge clk);
    reset   = 1'b1;
    man_ack = 1'b0;
    @(negedge clk);
    model_reset();
    check("t4_req", 32'(req_o), 32'd0);
    check("t4_data", data_o, 32'd0);
    check("t4_cnt", 32'(xfer_cnt), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_ready_in_reset", 32'(s_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t4_ready_after", 32'(s_ready), 32'd1);

    // 5: 17 transfers with random ack latency, counter wraps at 2^CNT_W
    dest_ack = 1'b0;
    dest_en  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dest_lat = $urandom_range(1, 3);
      send_word(DATA_W'($urandom));
      wait_idle(cyc);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    check("t5_wrapped_cnt", 32'(xfer_cnt), 32'd1);
    check("t5_err", 32'(err), 32'd0);

    // 6: ack withheld; err after TIMEOUT_CYC WAIT_ACK cycles when enabled
    do_reset();
    dest_en = 1'b0;
    man_ack = 1'b0;
    dest_ack = 1'b0;
    send_word(32'h0BAD_F00D);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("t6_err_progress", 32'(err), 32'(TO_EN && (i >= TIMEOUT_CYC)));
    end
    check("t6_still_busy", 32'(busy), 32'd1);
    man_ack = exp_req;
    wait_idle(cyc);
    check("t6_err_sticky", 32'(err), 32'(TO_EN));
    do_reset();
    check("t6_err_cleared", 32'(err), 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cdc_handshake_tx

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-domain end of a two-phase (toggle) req/ack clock-domain-crossing handshake. It carries control words, such as MIDI/parameter updates, into the audio clock domain. It accepts a word on a valid/ready interface, holds it stable on data_o, toggles req_o, then waits for the destination's ack toggle, which it brings in through an internal synchronizer chain. The receive-side capture block in the destination domain is the counterpart.

Parameters:
DATA_W, 32, width of transferred word
SYNC_STAGES, 2, flops in ack_i synchronizer chain (legal ≥2)
CNT_W, 16, width of transfer counter
TIMEOUT_CYC, 1024, WAIT_ACK cycles before err (only with HS_TIMEOUT_EN)

Ports:
clk  in  1  source-domain clock; the only clock of the block
reset  in  1  synchronous, active-high reset
s_valid  in  1  upstream word valid
s_ready  out  1  block can accept a word this cycle
s_data  in  DATA_W  upstream word
req_o  out  1  toggle request to destination domain (registered)
data_o  out  DATA_W  held word to destination domain (registered)
ack_i  in  1  toggle ack from destination domain; asynchronous to clk
busy  out  1  transfer in flight
xfer_cnt  out  CNT_W  completed transfers, wraps modulo 2^CNT_W
err  out  1  ack timeout, sticky (0 when feature compiled out)

Behaviour:
- One clock (clk). Reset is synchronous, active-high (reset). All state updates happen on posedge clk.
- Reset values: req_o=0, data_o=0, sync chain=all 0, state=IDLE, xfer_cnt=0, err=0, busy=0.
- While reset is high, s_ready=0.
- ack_s is the last stage of the ack_i chain. Minimum ack_i-to-ack_s latency is SYNC_STAGES cycles.
- s_ready = (state==IDLE) && (ack_s==req_o) && !reset. This is combinational from registers.
- States:
  - IDLE: if s_valid && s_ready, then data_o<=s_data, req_o<=~req_o, go to WAIT_ACK. Otherwise hold.
  - WAIT_ACK: busy=1, s_ready=0. When ack_s==req_o, go to IDLE and xfer_cnt<=xfer_cnt+1.
- Latency: a word accepted at edge N appears on req_o/data_o after edge N.
- data_o is stable from the req toggle until the ack is observed, and remains stable in IDLE until the next accept.
- Back-to-back transfers: s_ready rises the cycle after the return to IDLE. Minimum period is dest_latency + SYNC_STAGES + 2 cycles.
- ack_s != req_o while in IDLE (spurious toggle, or destination still in reset): s_ready is held 0 until they match. No accept occurs and there is no error.
- s_valid held with s_ready=0: no effect. s_data is ignored.
- xfer_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-transfer: the in-flight word is abandoned and req_o returns to 0. The destination must be reset in the same window. If it is not, the stalled-ready rule above holds off traffic until ack_s returns to 0.

Optional Feature:
- Macro: HS_TIMEOUT_EN.
- When defined:
  - A timeout counter, width $clog2(TIMEOUT_CYC+1), clears on entry to WAIT_ACK and increments each WAIT_ACK cycle, saturating.
  - When the count reaches TIMEOUT_CYC, err<=1. err stays set until reset.
  - The FSM keeps waiting, so a late ack still completes the transfer.
- When undefined: no counter is built and err is tied to 0.

Decomposition:
- Package cdc_pkg holds:
  - the state enum (IDLE, WAIT_ACK);
  - the default SYNC_STAGES constant;
  - the default DATA_W constant.
- Sub-module ack_sync_chain: parameterised-depth flop chain with synchronous reset. It is instantiated once for ack_i.

Test Plan:
- Reset, then s_valid=1, s_data=32'hA5A5_0001. Expect req_o 0→1 and data_o=A5A5_0001 the next cycle, busy=1. Toggle ack_i to 1; busy falls SYNC_STAGES+1 cycles later and xfer_cnt=1.
- Four words with the destination model acking 3 cycles after req. Expect req_o=1,0,1,0, data_o to match each word in order, data_o stable through every WAIT_ACK, and xfer_cnt=4.
- ack_i toggled while IDLE with no request. Expect s_ready=0 until ack_i is restored. No accept and no err.
- Assert reset during WAIT_ACK. Expect req_o=0, data_o=0, xfer_cnt=0, state IDLE next cycle. With ack_i=0, s_ready=1 one cycle after reset drops.
- CNT_W=4, 17 transfers. Expect xfer_cnt to wrap to 0 at 16 and read 1.
- HS_TIMEOUT_EN, TIMEOUT_CYC=8, ack withheld. Expect err=1 after 8 WAIT_ACK cycles. A late ack then completes the transfer and err stays 1. Without the macro, err=0 throughout.
